b16_sram_bridge: RTL

- Sits directly downstream of the b16 cpu core. It consumes the core's address, read strobe, byte-write strobes and write data, and returns read data.
- Drives an external asynchronous 16-bit SRAM with programmable wait states.
- Stalls the core by deasserting `run` until each access completes.
- Also gates the debugger's `drun` so that the core and debugger share one bus cleanly.

---
 rtl/b16_sram_bridge_if.sv | 47 ++++
 rtl/b16_sram_bridge.sv | 134 +++++++++++++
 2 files changed

// File: rtl/b16_sram_bridge_if.sv
// rtl/b16_sram_bridge_if.sv - b16 core / async SRAM bus bundle for b16_sram_bridge
// Optional I/O window signals exist only when B16_IOWIN_EN is defined.
interface b16_sram_bridge_if #(parameter int l = 16);
  logic [l-1:0] cpu_addr;
  logic         cpu_rd;
  logic [1:0]   cpu_wr;
  logic [l-1:0] cpu_dout;
  logic [l-1:0] cpu_din;
  logic         dbg_run;
  logic         run;
  logic [l-2:0] sram_a;
  logic [l-1:0] sram_dq_o;
  logic [l-1:0] sram_dq_i;
  logic         sram_dq_oe;
  logic         sram_ce_n;
  logic         sram_oe_n;
  logic         sram_we_n;
  logic         sram_ub_n;
  logic         sram_lb_n;
`ifdef B16_IOWIN_EN
  logic         io_rd;
  logic [1:0]   io_wr;
  logic [l-1:0] io_din;

  modport master (
    output cpu_addr, cpu_rd, cpu_wr, cpu_dout, dbg_run, sram_dq_i, io_din,
    input  cpu_din, run, sram_a, sram_dq_o, sram_dq_oe,
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, io_rd, io_wr
  );
  modport slave (
    input  cpu_addr, cpu_rd, cpu_wr, cpu_dout, dbg_run, sram_dq_i, io_din,
    output cpu_din, run, sram_a, sram_dq_o, sram_dq_oe,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, io_rd, io_wr
  );
`else
  modport master (
    output cpu_addr, cpu_rd, cpu_wr, cpu_dout, dbg_run, sram_dq_i,
    input  cpu_din, run, sram_a, sram_dq_o, sram_dq_oe,
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );
  modport slave (
    input  cpu_addr, cpu_rd, cpu_wr, cpu_dout, dbg_run, sram_dq_i,
    output cpu_din, run, sram_a, sram_dq_o, sram_dq_oe,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );
`endif
endinterface

// File: rtl/b16_sram_bridge.sv
// rtl/b16_sram_bridge.sv - b16 core to async 16-bit SRAM bridge with wait states and run gating
// Define B16_IOWIN_EN to add a zero-wait I/O window at cpu_addr[15:8] == iobase.
module b16_sram_bridge #(
  parameter int          l      = 16,
  parameter int          ws     = 2,
  parameter logic [7:0]  iobase = 8'hFF
) (
  input  logic clk,
  input  logic nreset,
  b16_sram_bridge_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic [l-2:0] r_addr;
  logic         r_rd;
  logic [1:0]   r_wr;
  logic [l-1:0] r_data;
  logic [l-1:0] r_dq_o;
  logic         r_dq_oe;
  logic         r_ce_n;
  logic         r_oe_n;
  logic         r_we_n;
  logic         r_ub_n;
  logic         r_lb_n;

  logic w_io_hit;
  logic w_req;
  logic w_match;
  logic w_run;
  logic w_unused;

`ifdef B16_IOWIN_EN
  assign w_io_hit    = (bus.cpu_addr[l-1:l-8] == iobase);
  assign bus.io_rd   = bus.cpu_rd & bus.dbg_run & w_io_hit & (r_state == IDLE);
  assign bus.io_wr   = bus.cpu_wr & {2{bus.dbg_run & w_io_hit & (r_state == IDLE)}};
  assign bus.cpu_din = ((r_state == IDLE) && w_io_hit) ? bus.io_din : r_data;
  assign w_unused    = bus.cpu_addr[0];
`else
  assign w_io_hit    = 1'b0;
  assign bus.cpu_din = r_data;
  assign w_unused    = ^{bus.cpu_addr[0], iobase};
`endif

  // I/O window hits never become SRAM requests, so run passes straight through for them
  assign w_req   = (bus.cpu_rd | (|bus.cpu_wr)) & ~w_io_hit;
  assign w_match = (bus.cpu_addr[l-1:1] == r_addr) & (bus.cpu_rd == r_rd) & (bus.cpu_wr == r_wr);

  always_comb begin
    w_run = 1'b0;
    case (r_state)
      IDLE:    w_run = bus.dbg_run & ~w_req;
      DONE:    w_run = bus.dbg_run & w_match;
      default: w_run = 1'b0;
    endcase
  end

  assign bus.run        = nreset & w_run;
  assign bus.sram_a     = r_addr;
  assign bus.sram_dq_o  = r_dq_o;
  assign bus.sram_dq_oe = r_dq_oe;
  assign bus.sram_ce_n  = r_ce_n;
  assign bus.sram_oe_n  = r_oe_n;
  assign bus.sram_we_n  = r_we_n;
  assign bus.sram_ub_n  = r_ub_n;
  assign bus.sram_lb_n  = r_lb_n;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 2'b00;
      r_data  <= '0;
      r_dq_o  <= '0;
      r_dq_oe <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_ub_n  <= 1'b1;
      r_lb_n  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && bus.dbg_run) begin
            r_addr  <= bus.cpu_addr[l-1:1];
            r_rd    <= bus.cpu_rd;
            r_wr    <= bus.cpu_wr;
            r_dq_o  <= bus.cpu_dout;
            r_cnt   <= 4'(ws);
            r_ce_n  <= 1'b0;
            r_state <= ACCESS;
            // writes win when the core raises both strobes
            if (|bus.cpu_wr) begin
              r_we_n  <= 1'b0;
              r_ub_n  <= ~bus.cpu_wr[1];
              r_lb_n  <= ~bus.cpu_wr[0];
              r_dq_oe <= 1'b1;
            end else begin
              r_oe_n  <= 1'b0;
              r_ub_n  <= 1'b0;
              r_lb_n  <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            if (r_wr == 2'b00) r_data <= bus.sram_dq_i;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_ub_n  <= 1'b1;
            r_lb_n  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          // address and write data stay driven through DONE for SRAM hold time
          if (!w_match || bus.dbg_run) begin
            r_dq_oe <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
